fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
- Instruction-side front end of the simple RISC CPU; sits directly upstream of the control FSM.
- Holds the program counter (PC), instruction register (IR) and data address register (DA), and drives the RAM address mux.
- Splits the registered instruction into the opcode/ALU_op fields consumed by the controller and the register/immediate fields consumed by the datapath.
- Updated only under the controller's load_pc, load_ir, load_addr, clear_pc and sel_addr strobes.

Parameters:
ADDR_W, 8, width of PC, DA and mem_addr
DATA_W, 16, instruction/data word width (fixed 16 for the ISA encoding)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
load_pc  input  1  PC update strobe from controller
clear_pc  input  1  force PC to 0
load_ir  input  1  capture ram_r_data into IR
load_addr  input  1  capture datapath_out[ADDR_W-1:0] into DA
sel_addr  input  1  1: mem_addr=PC, 0: mem_addr=DA
reg_sel  input  2  register-file index select from controller
ram_r_data  input  DATA_W  RAM read data
datapath_out  input  DATA_W  datapath C output (address source for LDR/STR)
mem_addr  output  ADDR_W  RAM address
opcode  output  3  IR[15:13]
ALU_op  output  2  IR[12:11]
shift_op  output  2  IR[4:3]
r_addr  output  3  selected register index
sximm8  output  DATA_W  sign-extended IR[7:0]
sximm5  output  DATA_W  sign-extended IR[4:0]
pc_out  output  ADDR_W  current PC
instr_count  output  16  instructions fetched since reset
illegal  output  1  sticky undefined-opcode flag

Behaviour:
- Reset, checked when rst_n=0 at the clk edge: PC=0, IR=16'h0000, DA=0, instr_count=0, illegal=0. Reset dominates every strobe.
- PC update priority: clear_pc=1 gives PC<=0, whether or not load_pc is asserted. Otherwise load_pc=1 gives PC<=PC+1 mod 2^ADDR_W, so 8'hFF wraps to 8'h00. Otherwise PC holds.
- IR: load_ir=1 gives IR<=ram_r_data. The new fields are visible the cycle after the edge, so opcode/ALU_op reach the controller with 1-cycle latency from load_ir.
- DA: load_addr=1 gives DA<=datapath_out[ADDR_W-1:0]; upper bits are ignored.
- Simultaneous load_pc and load_ir (the controller's fetch state): IR captures the word addressed by the old PC, and PC advances. There is no hazard because mem_addr is sampled from the pre-edge PC.
- mem_addr is combinational: sel_addr ? PC : DA.
- r_addr is combinational from IR:
  - reg_sel 2'b10: Rn=IR[10:8]
  - reg_sel 2'b01: Rd=IR[7:5]
  - reg_sel 2'b00: Rm=IR[2:0]
  - reg_sel 2'b11: Rm (reserved, same as 00)
- sximm8 = {{8{IR[7]}},IR[7:0]}; sximm5 = {{11{IR[4]}},IR[4:0]}.
- instr_count increments by 1 on each load_ir edge and saturates at 16'hFFFF (no wrap). clear_pc does not reset it.
- illegal:
  - Legal opcodes are 3'b011 LDR, 3'b100 STR, 3'b101 ALU, 3'b110 MOV, 3'b111 HALT.
  - On load_ir with ram_r_data[15:13] not in that set, illegal<=1.
  - Once set it holds until rst_n=0 or clear_pc=1.
  - If clear_pc and a load_ir of an illegal opcode occur in the same cycle, the set wins (illegal=1).
- No internal FSM; sequencing is entirely controller-driven. Every register holds whenever its strobe is low.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_LDR, OP_STR, OP_ALU, OP_MOV, OP_HALT
  - reg_sel encodings SEL_RN, SEL_RD, SEL_RM
  - IR field bit-position localparams, shared with the controller
- One sub-module is natural: sign_ext (parameterised IN_W/OUT_W), instantiated twice for sximm8 and sximm5.
- The PC, IR and DA registers stay inline.

Test Plan:
- Reset then fetch: rst_n=0 for 1 cycle, then load_pc=load_ir=1, sel_addr=1, ram_r_data=16'hD105. Required next cycle: PC=1, IR=16'hD105, opcode=3'b110, ALU_op=2'b10, sximm8=16'h0005, instr_count=1.
- PC wrap and clear priority:
  - Step 1: preload PC=8'hFF, load_pc=1. Required: PC=8'h00.
  - Step 2: drive load_pc=1 and clear_pc=1 together at PC=8'h05. Required: PC=8'h00.
- Address mux and DA:
  - Step 1: datapath_out=16'hAB3C, load_addr=1. Required: DA=8'h3C.
  - Step 2: sel_addr=0. Required: mem_addr=8'h3C.
  - Step 3: sel_addr=1 with PC=8'h07. Required: mem_addr=8'h07.
- Field decode: IR=16'hA2F3 (Rn=2, Rd=7, shift=2'b10, Rm=3). Required r_addr for reg_sel 10/01/00/11 = 2/7/3/3. Required sximm5=16'hFFF3.
- Illegal opcode:
  - Step 1: load_ir with ram_r_data=16'h2000 (opcode 001). Required: illegal=1, and it holds through 3 legal fetches.
  - Step 2: clear_pc=1. Required: illegal=0.
  - Step 3: simultaneous clear_pc and illegal load. Required: illegal=1.
- Counter saturation and mid-run reset:
  - Step 1: force instr_count=16'hFFFE, then 3 load_ir pulses. Required: 16'hFFFF.
  - Step 2: rst_n=0 asserted alongside load_ir/load_pc. Required: all registers 0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end and the controller:
// opcode and register-select encodings plus instruction-register field positions.
package cpu_pkg;

  // Opcodes the ISA defines; every other 3-bit value is undefined.
  typedef enum logic [2:0] {
    OP_LDR  = 3'b011,
    OP_STR  = 3'b100,
    OP_ALU  = 3'b101,
    OP_MOV  = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  // Register-file index selection driven by the controller.
  // 2'b11 is reserved and behaves like SEL_RM.
  typedef enum logic [1:0] {
    SEL_RM     = 2'b00,
    SEL_RD     = 2'b01,
    SEL_RN     = 2'b10,
    SEL_RM_ALT = 2'b11
  } regSel_t;

  // Instruction register field positions (16-bit encoding).
  localparam int IR_OPCODE_HI = 15;
  localparam int IR_OPCODE_LO = 13;
  localparam int IR_ALUOP_HI  = 12;
  localparam int IR_ALUOP_LO  = 11;
  localparam int IR_RN_HI     = 10;
  localparam int IR_RN_LO     = 8;
  localparam int IR_RD_HI     = 7;
  localparam int IR_RD_LO     = 5;
  localparam int IR_SHIFT_HI  = 4;
  localparam int IR_SHIFT_LO  = 3;
  localparam int IR_RM_HI     = 2;
  localparam int IR_RM_LO     = 0;

  // Immediate field widths; both immediates start at bit 0.
  localparam int IMM8_W = 8;
  localparam int IMM5_W = 5;

  // True when the opcode field names a defined instruction.
  function automatic logic isLegalOpcode(input logic [2:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_LDR, OP_STR, OP_ALU, OP_MOV, OP_HALT: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Bus between the controller/memory side and the fetch/decode front end.
// The master drives strobes and memory/datapath data; the slave (front end)
// returns the memory address and the decoded instruction fields.
interface fetch_decode_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  // Controller strobes
  logic              load_pc;
  logic              clear_pc;
  logic              load_ir;
  logic              load_addr;
  logic              sel_addr;
  logic [1:0]        reg_sel;

  // Data sources
  logic [DATA_W-1:0] ram_r_data;
  logic [DATA_W-1:0] datapath_out;

  // Front-end results
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        opcode;
  logic [1:0]        ALU_op;
  logic [1:0]        shift_op;
  logic [2:0]        r_addr;
  logic [DATA_W-1:0] sximm8;
  logic [DATA_W-1:0] sximm5;
  logic [ADDR_W-1:0] pc_out;
  logic [15:0]       instr_count;
  logic              illegal;

  modport master (
    output load_pc, clear_pc, load_ir, load_addr, sel_addr, reg_sel,
    output ram_r_data, datapath_out,
    input  mem_addr, opcode, ALU_op, shift_op, r_addr,
    input  sximm8, sximm5, pc_out, instr_count, illegal
  );

  modport slave (
    input  load_pc, clear_pc, load_ir, load_addr, sel_addr, reg_sel,
    input  ram_r_data, datapath_out,
    output mem_addr, opcode, ALU_op, shift_op, r_addr,
    output sximm8, sximm5, pc_out, instr_count, illegal
  );

endinterface

// File: rtl/fetch_decode_unit_sign_ext.sv
// Generic sign extender: replicates the top input bit up to OUT_W bits.
module sign_ext #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_value,
  output logic [OUT_W-1:0] o_value
);

  assign o_value = {{(OUT_W - IN_W){i_value[IN_W-1]}}, i_value};

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction-side front end: PC, IR and data-address registers, the RAM
// address mux, and decode of the registered instruction into the fields
// used by the controller and the datapath. All sequencing comes from the
// controller's strobes; every register holds while its strobe is low.
module fetch_decode_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  fetch_decode_unit_if.slave bus
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_da;
  logic [DATA_W-1:0] r_ir;
  logic [15:0]       r_instrCount;
  logic              r_illegal;

  logic              w_loadIllegal;
  logic [2:0]        w_rAddr;
  logic [DATA_W-1:0] w_sximm8;
  logic [DATA_W-1:0] w_sximm5;

  // The opcode is judged on the incoming word so the flag lines up with the IR load.
  assign w_loadIllegal = bus.load_ir &&
                         !isLegalOpcode(bus.ram_r_data[IR_OPCODE_HI:IR_OPCODE_LO]);

  // Program counter: clear beats increment; increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (bus.clear_pc) begin
      r_pc <= '0;
    end else if (bus.load_pc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  // Instruction register: captures the word addressed by the pre-edge PC during fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ir <= '0;
    end else if (bus.load_ir) begin
      r_ir <= bus.ram_r_data;
    end
  end

  // Data address register: only the low address bits of the datapath result matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_da <= '0;
    end else if (bus.load_addr) begin
      r_da <= bus.datapath_out[ADDR_W-1:0];
    end
  end

  // Fetch counter: saturates instead of wrapping, and survives clear_pc.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instrCount <= '0;
    end else if (bus.load_ir && (r_instrCount != 16'hFFFF)) begin
      r_instrCount <= r_instrCount + 16'd1;
    end
  end

  // Sticky undefined-opcode flag: a new illegal load wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_loadIllegal) begin
      r_illegal <= 1'b1;
    end else if (bus.clear_pc) begin
      r_illegal <= 1'b0;
    end
  end

  // Register index select; the reserved encoding falls back to Rm.
  always_comb begin
    w_rAddr = r_ir[IR_RM_HI:IR_RM_LO];
    case (bus.reg_sel)
      SEL_RN:  w_rAddr = r_ir[IR_RN_HI:IR_RN_LO];
      SEL_RD:  w_rAddr = r_ir[IR_RD_HI:IR_RD_LO];
      default: w_rAddr = r_ir[IR_RM_HI:IR_RM_LO];
    endcase
  end

  sign_ext #(
    .IN_W  (IMM8_W),
    .OUT_W (DATA_W)
  ) u_sxImm8 (
    .i_value (r_ir[IMM8_W-1:0]),
    .o_value (w_sximm8)
  );

  sign_ext #(
    .IN_W  (IMM5_W),
    .OUT_W (DATA_W)
  ) u_sxImm5 (
    .i_value (r_ir[IMM5_W-1:0]),
    .o_value (w_sximm5)
  );

  assign bus.mem_addr    = bus.sel_addr ? r_pc : r_da;
  assign bus.opcode      = r_ir[IR_OPCODE_HI:IR_OPCODE_LO];
  assign bus.ALU_op      = r_ir[IR_ALUOP_HI:IR_ALUOP_LO];
  assign bus.shift_op    = r_ir[IR_SHIFT_HI:IR_SHIFT_LO];
  assign bus.r_addr      = w_rAddr;
  assign bus.sximm8      = w_sximm8;
  assign bus.sximm5      = w_sximm5;
  assign bus.pc_out      = r_pc;
  assign bus.instr_count = r_instrCount;
  assign bus.illegal     = r_illegal;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: directed scenarios followed by
// randomized strobes, all compared against a behavioural model of the
// architectural state (PC, IR, DA, fetch count, illegal flag).
module tb_fetch_decode_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fetch_decode_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  fetch_decode_unit #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference state, kept as plain integers
  int mPc, mIr, mDa, mCount;
  bit mIllegal;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rstN, input bit lpc, input bit cpc, input bit lir,
                               input bit laddr, input bit sel, input bit [1:0] rs,
                               input bit [15:0] data, input bit [15:0] dpo);
    rst_n            = rstN;
    bus.load_pc      = lpc;
    bus.clear_pc     = cpc;
    bus.load_ir      = lir;
    bus.load_addr    = laddr;
    bus.sel_addr     = sel;
    bus.reg_sel      = rs;
    bus.ram_r_data   = data;
    bus.datapath_out = dpo;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    int op;
    if (!rst_n) begin
      mPc = 0; mIr = 0; mDa = 0; mCount = 0; mIllegal = 0;
    end else begin
      op = int'(bus.ram_r_data) / 8192;
      if (bus.load_ir && op < 3) mIllegal = 1;
      else if (bus.clear_pc)     mIllegal = 0;
      if (bus.load_ir) begin
        mIr = int'(bus.ram_r_data);
        if (mCount < 65535) mCount = mCount + 1;
      end
      if (bus.clear_pc)     mPc = 0;
      else if (bus.load_pc) mPc = (mPc + 1) % 256;
      if (bus.load_addr)    mDa = int'(bus.datapath_out) % 256;
    end
  endtask

  // Compare every output against values derived from the model state.
  task automatic checkAll(input string where);
    int expMem, expRAddr, expSx8, expSx5;
    expMem = bus.sel_addr ? mPc : mDa;
    case (bus.reg_sel)
      2'b10:   expRAddr = (mIr / 256) % 8;
      2'b01:   expRAddr = (mIr / 32) % 8;
      default: expRAddr = mIr % 8;
    endcase
    expSx8 = (mIr % 256 >= 128) ? 65280 + (mIr % 256) : mIr % 256;
    expSx5 = (mIr % 32 >= 16) ? 65504 + (mIr % 32) : mIr % 32;
    checkOutput({where, ".pc"},       int'(bus.pc_out),      mPc);
    checkOutput({where, ".mem_addr"}, int'(bus.mem_addr),    expMem);
    checkOutput({where, ".opcode"},   int'(bus.opcode),      mIr / 8192);
    checkOutput({where, ".alu_op"},   int'(bus.ALU_op),      (mIr / 2048) % 4);
    checkOutput({where, ".shift_op"}, int'(bus.shift_op),    (mIr / 8) % 4);
    checkOutput({where, ".r_addr"},   int'(bus.r_addr),      expRAddr);
    checkOutput({where, ".sximm8"},   int'(bus.sximm8),      expSx8);
    checkOutput({where, ".sximm5"},   int'(bus.sximm5),      expSx5);
    checkOutput({where, ".count"},    int'(bus.instr_count), mCount);
    checkOutput({where, ".illegal"},  int'(bus.illegal),     int'(mIllegal));
  endtask

  // Drive one cycle of inputs at the falling edge, clock it, then optionally check.
  task automatic runCycle(input string where, input bit doCheck, input bit rstN,
                          input bit lpc, input bit cpc, input bit lir, input bit laddr,
                          input bit sel, input bit [1:0] rs,
                          input bit [15:0] data, input bit [15:0] dpo);
    @(negedge clk);
    applyStimulus(rstN, lpc, cpc, lir, laddr, sel, rs, data, dpo);
    modelEdge();
    @(posedge clk);
    #1;
    if (doCheck) checkAll(where);
  endtask

  initial begin
    bit [1:0] regSels [4];
    int       expRAddrs [4];
    mPc = 0; mIr = 0; mDa = 0; mCount = 0; mIllegal = 0;
    applyStimulus(0, 0, 0, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);

    // Reset state
    runCycle("reset", 1, 0, 0, 0, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);
    checkOutput("reset.pc", int'(bus.pc_out), 0);
    checkOutput("reset.count", int'(bus.instr_count), 0);
    checkOutput("reset.illegal", int'(bus.illegal), 0);

    // First fetch: IR takes the word, PC advances
    runCycle("fetch", 1, 1, 1, 0, 1, 0, 1, 2'b00, 16'hD105, 16'h0000);
    checkOutput("fetch.pc", int'(bus.pc_out), 1);
    checkOutput("fetch.opcode", int'(bus.opcode), 6);
    checkOutput("fetch.alu_op", int'(bus.ALU_op), 2);
    checkOutput("fetch.sximm8", int'(bus.sximm8), 16'h0005);
    checkOutput("fetch.count", int'(bus.instr_count), 1);

    // PC wrap from FF to 00
    runCycle("wrap.clear", 1, 1, 0, 1, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);
    for (int i = 0; i < 255; i++)
      runCycle("wrap.inc", 1, 1, 1, 0, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);
    checkOutput("wrap.pc_ff", int'(bus.pc_out), 8'hFF);
    runCycle("wrap.step", 1, 1, 1, 0, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);
    checkOutput("wrap.pc_00", int'(bus.pc_out), 0);

    // clear_pc has priority over load_pc
    for (int i = 0; i < 5; i++)
      runCycle("prio.inc", 1, 1, 1, 0, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);
    checkOutput("prio.pc_05", int'(bus.pc_out), 5);
    runCycle("prio.both", 1, 1, 1, 1, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);
    checkOutput("prio.pc", int'(bus.pc_out), 0);

    // Data address register and address mux
    runCycle("da.load", 1, 1, 0, 0, 0, 1, 1, 2'b00, 16'h0000, 16'hAB3C);
    runCycle("da.sel0", 1, 1, 0, 0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000);
    checkOutput("da.mem_addr", int'(bus.mem_addr), 8'h3C);
    for (int i = 0; i < 7; i++)
      runCycle("da.pcinc", 1, 1, 1, 0, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);
    checkOutput("pcsel.mem_addr", int'(bus.mem_addr), 8'h07);

    // Field decode of A2F3 across all reg_sel values
    runCycle("decode.load", 1, 1, 0, 0, 1, 0, 1, 2'b00, 16'hA2F3, 16'h0000);
    regSels   = '{2'b10, 2'b01, 2'b00, 2'b11};
    expRAddrs = '{2, 7, 3, 3};
    for (int i = 0; i < 4; i++) begin
      runCycle("decode.sel", 1, 1, 0, 0, 0, 0, 1, regSels[i], 16'h0000, 16'h0000);
      checkOutput("decode.r_addr", int'(bus.r_addr), expRAddrs[i]);
    end
    checkOutput("decode.sximm5", int'(bus.sximm5), 16'hFFF3);
    checkOutput("decode.shift_op", int'(bus.shift_op), 2);

    // Illegal opcode: set, hold through legal fetches, clear, set-beats-clear
    runCycle("illegal.set", 1, 1, 0, 0, 1, 0, 1, 2'b00, 16'h2000, 16'h0000);
    checkOutput("illegal.set", int'(bus.illegal), 1);
    runCycle("illegal.hold", 1, 1, 1, 0, 1, 0, 1, 2'b00, 16'h6000, 16'h0000);
    runCycle("illegal.hold", 1, 1, 1, 0, 1, 0, 1, 2'b00, 16'h8000, 16'h0000);
    runCycle("illegal.hold", 1, 1, 1, 0, 1, 0, 1, 2'b00, 16'hE000, 16'h0000);
    checkOutput("illegal.hold", int'(bus.illegal), 1);
    runCycle("illegal.clear", 1, 1, 0, 1, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);
    checkOutput("illegal.clear", int'(bus.illegal), 0);
    runCycle("illegal.race", 1, 1, 0, 1, 1, 0, 1, 2'b00, 16'h2000, 16'h0000);
    checkOutput("illegal.race", int'(bus.illegal), 1);

    // Counter saturation: bring the count to FFFE, then three more fetches
    runCycle("sat.reset", 1, 0, 0, 0, 0, 0, 1, 2'b00, 16'h0000, 16'h0000);
    for (int i = 0; i < 65534; i++)
      runCycle("sat.fill", 0, 1, 0, 0, 1, 0, 1, 2'b00, 16'hA000, 16'h0000);
    checkAll("sat.fill");
    checkOutput("sat.count_fffe", int'(bus.instr_count), 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      runCycle("sat.top", 1, 1, 0, 0, 1, 0, 1, 2'b00, 16'h6000, 16'h0000);
      checkOutput("sat.count_ffff", int'(bus.instr_count), 16'hFFFF);
    end

    // Mid-run reset dominates load_ir/load_pc
    runCycle("midrst.prep", 1, 1, 1, 0, 1, 1, 1, 2'b00, 16'h2000, 16'h00FF);
    runCycle("midrst", 1, 0, 1, 0, 1, 0, 0, 2'b00, 16'hD105, 16'h0000);
    checkOutput("midrst.pc", int'(bus.pc_out), 0);
    checkOutput("midrst.da", int'(bus.mem_addr), 0);
    checkOutput("midrst.opcode", int'(bus.opcode), 0);
    checkOutput("midrst.count", int'(bus.instr_count), 0);
    checkOutput("midrst.illegal", int'(bus.illegal), 0);

    // Randomized strobes and data against the model
    for (int i = 0; i < 400; i++) begin
      runCycle("rand", 1,
               ($urandom_range(0, 39) != 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)),
               16'($urandom),
               16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
